instr_mem_fetch: RTL and testbench
==================================

Name: instr_mem_fetch

Overview:
Parametrised successor to the processor's instruction memory. The old block was a fixed combinational ROM; this block holds the program in a RAM that can be loaded at run time. It reads that RAM synchronously behind a valid/ready fetch handshake, clears itself after reset, and flags out-of-range fetches. It sits between the PC/fetch stage and decode, and its load port is driven by the boot loader.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 6, width of the fetch and load addresses
DEPTH, 64, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
NOP_WORD, 0, word returned for out-of-range fetches and written by the clear sweep

Ports:
clk  in  1  single clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
load_en  in  1  write strobe from the boot loader
load_addr  in  ADDR_W  write address
load_data  in  DATA_W  write data
fetch_req  in  1  fetch request (valid) from the PC stage
fetch_addr  in  ADDR_W  PC word address to fetch
fetch_ready  in  1  decode stage can accept the output word
fetch_gnt  out  1  request accepted this cycle (combinational)
instr_valid  out  1  instr_out holds a word
instr_out  out  DATA_W  fetched instruction
instr_addr  out  ADDR_W  address that instr_out came from
addr_err  out  1  current instr_valid beat came from an address >= DEPTH
busy  out  1  clear sweep in progress

Behaviour:
- Reset (asserted at any time, including mid-fetch or mid-sweep) takes effect asynchronously:
  - outputs: instr_valid=0, instr_out=NOP_WORD, instr_addr=0, addr_err=0, busy=1;
  - state goes to CLEAR and the sweep counter goes to 0.
- State CLEAR:
  - each cycle writes NOP_WORD to RAM[cnt], then cnt increments;
  - after the write at cnt=DEPTH-1, the next state is RUN and busy drops to 0;
  - the sweep takes exactly DEPTH cycles after reset is released;
  - load_en and fetch_req are ignored and fetch_gnt=0.
- State RUN, load:
  - when load_en=1 and load_addr<DEPTH, RAM[load_addr] is written at the edge;
  - when load_addr>=DEPTH the write is dropped silently;
  - loads never stall fetches.
- State RUN, fetch grant:
  - fetch_gnt = fetch_req & (!instr_valid | fetch_ready).
- On a granted fetch, latency is 1 cycle. At the next edge:
  - instr_valid=1 and instr_addr=fetch_addr;
  - in range: instr_out=RAM[fetch_addr] and addr_err=0;
  - out of range (>=DEPTH): instr_out=NOP_WORD and addr_err=1.
- Load/fetch collision: a load and a granted fetch to the same address in the same cycle return the new load_data (write-first bypass).
- Back-pressure: while instr_valid=1 and fetch_ready=0, instr_out, instr_addr and addr_err hold stable and no new fetch is granted.
- Pop without refill: when instr_valid=1, fetch_ready=1 and fetch_req=0, instr_valid clears at the next edge.
- Throughput: with fetch_req and fetch_ready both held high, the block delivers one word per cycle with no bubbles.
- Ordering: words are delivered in grant order; there is no reordering and no buffering beyond the single output register.

Decomposition:
- Shared package:
  - state enum {CLEAR, RUN};
  - NOP_WORD default;
  - instruction-width constant shared with decode.
- One sub-module, instr_ram:
  - 1 write port and 1 synchronous read port, DEPTH x DATA_W;
  - no reset on the array, so it infers block RAM.
- The clear sweep, handshake and bypass logic live in the top level.

Test Plan:
1. Reset, then hold idle with DEPTH=64 -> busy=1 for exactly 64 cycles; a fetch of address 10 issued during the sweep gets no grant; after the sweep, a fetch of address 10 returns 0x00000000 with addr_err=0.
2. Load 0x00400005 at address 0, 0x00C00002 at 1 and 0x10640046 at 2; then fetch 0,1,2 back-to-back with fetch_ready=1 -> the three words appear on consecutive cycles with instr_addr 0,1,2, each one cycle after its grant.
3. With DEPTH=48, fetch address 50 -> instr_out=0, addr_err=1, instr_valid=1; a load to address 50 is dropped, and a later fetch of address 50 still returns 0.
4. Load 0xDEADBEEF to address 5 in the same cycle as a fetch of address 5 -> instr_out=0xDEADBEEF next cycle.
5. Hold fetch_ready=0 for 3 cycles with fetch_req=1 -> fetch_gnt=0 and the output stays stable; on raising fetch_ready, exactly one grant occurs per cycle and no word is lost or duplicated.
6. Assert rst mid-stream while instr_valid=1 -> instr_valid drops immediately (asynchronously), busy=1, and the clear sweep restarts from address 0.

Source files
------------

// File: rtl/instr_mem_fetch_pkg.sv
// rtl/instr_mem_fetch_pkg.sv - shared types and constants for the instruction fetch memory
package instr_mem_fetch_pkg;

    // Instruction width shared with the decode stage
    localparam int INSTR_W = 32;

    // Word returned for out-of-range fetches and written by the clear sweep
    localparam logic [INSTR_W-1:0] NOP_DEFAULT = '0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_mem_fetch_ram.sv
// rtl/instr_mem_fetch_ram.sv - DEPTH x DATA_W RAM, one write port, one registered read port
module instr_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset on the array or read register so this maps onto block RAM;
    // callers keep both addresses below DEPTH.
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and synchronous read port; rdata holds when re is low
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_fetch.sv
// rtl/instr_mem_fetch.sv - loadable instruction RAM with clear sweep and valid/ready fetch port
module instr_mem_fetch
    import instr_mem_fetch_pkg::*;
#(
    parameter int                DATA_W   = INSTR_W,
    parameter int                ADDR_W   = 6,
    parameter int                DEPTH    = 64,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ready,
    output logic              fetch_gnt,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              addr_err,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] cnt_q;

    logic              fetch_in_range;
    logic              load_in_range;
    logic              bypass_hit;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // Output word source: registered RAM data, or a captured word (bypass / NOP)
    logic              use_ram_q;
    logic [DATA_W-1:0] byp_data_q;

    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_X);
    assign load_in_range  = ({1'b0, load_addr} < DEPTH_X);
    // Same-cycle load to the fetched word: hand back the new data, not the stale RAM word
    assign bypass_hit     = load_en && load_in_range && (load_addr == fetch_addr);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep counter walks the array once after every reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Next state: leave CLEAR once the last implemented word has been written
    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && cnt_q == LAST_ADDR) begin
            state_d = RUN;
        end
    end

    // Outputs and RAM port control per state
    always_comb begin
        busy      = 1'b0;
        fetch_gnt = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = load_addr;
        ram_wdata = load_data;
        ram_re    = 1'b0;
        case (state_q)
            CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = NOP_WORD;
            end
            RUN: begin
                ram_we    = load_en && load_in_range;
                fetch_gnt = fetch_req && (!instr_valid || fetch_ready);
                ram_re    = fetch_gnt && fetch_in_range && !bypass_hit;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    instr_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (fetch_addr),
        .rdata (ram_rdata)
    );

    // Single output stage: load on grant, hold under back-pressure, drop on pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr_addr  <= '0;
            addr_err    <= 1'b0;
            use_ram_q   <= 1'b0;
            byp_data_q  <= NOP_WORD;
        end else if (fetch_gnt) begin
            instr_valid <= 1'b1;
            instr_addr  <= fetch_addr;
            addr_err    <= !fetch_in_range;
            use_ram_q   <= fetch_in_range && !bypass_hit;
            byp_data_q  <= bypass_hit ? load_data : NOP_WORD;
        end else if (fetch_ready) begin
            instr_valid <= 1'b0;
        end
    end

    assign instr_out = use_ram_q ? ram_rdata : byp_data_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb/tb_instr_mem_fetch.sv - randomized self-checking bench for instr_mem_fetch (DEPTH 64 and 48)
module tb_instr_mem_fetch;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready;

    logic [1:0]         gnt_v;
    logic [1:0]         valid_v;
    logic [1:0]         err_v;
    logic [1:0]         busy_v;
    logic [1:0][DW-1:0] out_v;
    logic [1:0][AW-1:0] addr_v;

    always #5 clk = ~clk;

    instr_mem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .NOP_WORD('0)) u_d64 (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_gnt(gnt_v[0]), .instr_valid(valid_v[0]), .instr_out(out_v[0]),
        .instr_addr(addr_v[0]), .addr_err(err_v[0]), .busy(busy_v[0])
    );

    instr_mem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(48), .NOP_WORD('0)) u_d48 (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_gnt(gnt_v[1]), .instr_valid(valid_v[1]), .instr_out(out_v[1]),
        .instr_addr(addr_v[1]), .addr_err(err_v[1]), .busy(busy_v[1])
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one memory image and one output slot per instance
    int            depth [2] = '{64, 48};
    logic [DW-1:0] mem   [2][64];
    bit            ev    [2];
    logic [DW-1:0] eout  [2];
    logic [AW-1:0] eaddr [2];
    bit            eerr  [2];
    int            sweep [2];

    function automatic bit model_gnt(int k);
        return (sweep[k] == 0) && fetch_req && (!ev[k] || fetch_ready);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ev[k] = 0; eout[k] = '0; eaddr[k] = '0; eerr[k] = 0; sweep[k] = depth[k];
            for (int i = 0; i < 64; i++) mem[k][i] = '0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit g;
            g = model_gnt(k);
            if (sweep[k] > 0) begin
                sweep[k]--;
            end else begin
                if (g) begin
                    ev[k] = 1;
                    eaddr[k] = fetch_addr;
                    if (int'(fetch_addr) < depth[k]) begin
                        eerr[k] = 0;
                        eout[k] = (load_en && load_addr == fetch_addr) ? load_data : mem[k][fetch_addr];
                    end else begin
                        eerr[k] = 1;
                        eout[k] = '0;
                    end
                end else if (fetch_ready) begin
                    ev[k] = 0;
                end
                if (load_en && int'(load_addr) < depth[k]) mem[k][load_addr] = load_data;
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy_d%0d", depth[k]), 64'(busy_v[k]), 64'(sweep[k] != 0));
            check($sformatf("valid_d%0d", depth[k]), 64'(valid_v[k]), 64'(ev[k]));
            if (ev[k]) begin
                check($sformatf("out_d%0d", depth[k]), 64'(out_v[k]), 64'(eout[k]));
                check($sformatf("addr_d%0d", depth[k]), 64'(addr_v[k]), 64'(eaddr[k]));
                check($sformatf("err_d%0d", depth[k]), 64'(err_v[k]), 64'(eerr[k]));
            end
        end
    endtask

    // One clock: drive at the falling edge, check grant, step model at the rising edge
    task automatic tick(input bit le, input int la, input logic [31:0] ld,
                        input bit req, input int fa, input bit rdy);
        load_en = le; load_addr = AW'(la); load_data = ld;
        fetch_req = req; fetch_addr = AW'(fa); fetch_ready = rdy;
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("gnt_d%0d", depth[k]), 64'(gnt_v[k]), 64'(model_gnt(k)));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Reset raised between edges so the async path is what clears the outputs
    task automatic do_reset();
        load_en = 0; fetch_req = 0; fetch_ready = 1;
        #2;
        rst = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid_d%0d", depth[k]), 64'(valid_v[k]), 64'(0));
            check($sformatf("rst_busy_d%0d", depth[k]), 64'(busy_v[k]), 64'(1));
            check($sformatf("rst_out_d%0d", depth[k]), 64'(out_v[k]), 64'(0));
            check($sformatf("rst_addr_d%0d", depth[k]), 64'(addr_v[k]), 64'(0));
            check($sformatf("rst_err_d%0d", depth[k]), 64'(err_v[k]), 64'(0));
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 0; load_en = 0; load_addr = '0; load_data = '0;
        fetch_req = 0; fetch_addr = '0; fetch_ready = 1;
        @(negedge clk);
        do_reset();

        // Sweep with a pending fetch of address 10, then fetch after the sweep
        for (int i = 0; i < 64; i++) tick(0, 0, 0, 1, 10, 1);
        tick(0, 0, 0, 1, 10, 1);
        tick(0, 0, 0, 0, 0, 1);

        // Load three words then stream them back
        tick(1, 0, 32'h00400005, 0, 0, 1);
        tick(1, 1, 32'h00C00002, 0, 0, 1);
        tick(1, 2, 32'h10640046, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 1);
        tick(0, 0, 0, 1, 1, 1);
        tick(0, 0, 0, 1, 2, 1);
        tick(0, 0, 0, 0, 0, 1);

        // Address 50: out of range for DEPTH 48, a normal word for DEPTH 64
        tick(0, 0, 0, 1, 50, 1);
        tick(1, 50, 32'h12345678, 0, 0, 1);
        tick(0, 0, 0, 1, 50, 1);
        tick(0, 0, 0, 0, 0, 1);

        // Load/fetch collision
        tick(1, 5, 32'hDEADBEEF, 1, 5, 1);
        tick(0, 0, 0, 0, 0, 1);

        // Back-pressure for three cycles, then release
        tick(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 2, 0);
        tick(0, 0, 0, 1, 2, 1);
        tick(0, 0, 0, 1, 0, 1);
        tick(0, 0, 0, 0, 0, 1);

        // Reset mid-stream; loads during the new sweep must not land
        tick(0, 0, 0, 1, 2, 1);
        do_reset();
        for (int i = 0; i < 64; i++) tick(1, int'($urandom_range(0, 63)), $urandom, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 1);
        tick(0, 0, 0, 1, 5, 1);
        tick(0, 0, 0, 0, 0, 1);

        // Randomized traffic with biased collisions
        for (int i = 0; i < 3000; i++) begin
            int fa;
            int la;
            fa = int'($urandom_range(0, 63));
            la = ($urandom_range(0, 3) == 0) ? fa : int'($urandom_range(0, 63));
            if ($urandom_range(0, 999) == 0) do_reset();
            tick($urandom_range(0, 2) == 0, la, $urandom,
                 $urandom_range(0, 3) != 0, fa, $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
